operand_issue_stage: RTL
========================

// Module: operand_issue_stage
// PURPOSE
//  Issue stage directly downstream of the 8x16 register file. Takes a decoded
//  instruction and drives the file's two read ports. A per-register scoreboard
//  stalls on RAW/WAW hazards; writeback data is bypassed in the same cycle.
//  Operands are registered into an ID/EX output register with valid/ready flow.
// PARAMETERS
//  DATA_W   16  register/operand width
//  ADDR_W   3   register address width (2**ADDR_W registers, r0 hardwired 0)
//  OP_W     4   opaque opcode width, passed through unchanged
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-low reset
//  in_valid     in   1       decoded instruction present
//  in_ready     out  1       instruction accepted this cycle (combinational)
//  in_op        in   OP_W    opcode
//  in_src1      in   ADDR_W  source register 1
//  in_src2      in   ADDR_W  source register 2
//  in_use1      in   1       src1 is read
//  in_use2      in   1       src2 is read
//  in_dest      in   ADDR_W  destination register
//  in_wr        in   1       instruction writes in_dest
//  rf_rd_add1   out  ADDR_W  = in_src1 (combinational)
//  rf_rd_data1  in   DATA_W  register file read data 1
//  rf_rd_add2   out  ADDR_W  = in_src2 (combinational)
//  rf_rd_data2  in   DATA_W  register file read data 2
//  wb_en        in   1       writeback strobe (same net as file write enable)
//  wb_dest      in   ADDR_W  writeback register
//  wb_data      in   DATA_W  writeback data
//  flush        in   1       discard instruction held in output register
//  out_valid    out  1       output register holds an instruction
//  out_ready    in   1       downstream accepts output this cycle
//  out_op       out  OP_W    registered opcode
//  out_a        out  DATA_W  registered operand 1
//  out_b        out  DATA_W  registered operand 2
//  out_dest     out  ADDR_W  registered destination
//  out_wr       out  1       registered write flag
//  stall_cnt    out  16      saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0; out_op/a/b/dest/wr=0; scoreboard pend[]=0; stall_cnt=0.
//  - wclr(r) = wb_en & wb_dest==r & r!=0. Always clears pend[r] at the clock edge.
//  - busy(r) = r!=0 & pend[r] & !wclr(r).
//  - Operand k: 0 if src==0 or !use; wb_data if wclr(src); else rf_rd_datak.
//  - hazard = (in_use1&busy(src1)) | (in_use2&busy(src2)) | (in_wr&busy(in_dest)).
//  - slot_free = !out_valid | out_ready.
//  - in_ready = in_valid & !hazard & slot_free & !flush.
//  - Output register states: EMPTY (out_valid=0), FULL (out_valid=1).
//    - EMPTY -> FULL on in_ready.
//    - FULL -> EMPTY on out_ready & !in_ready.
//    - FULL -> FULL: holds if !out_ready; reloads if out_ready & in_ready.
//    - flush forces EMPTY and blocks acceptance that cycle.
//  - Latency: instruction accepted at edge N is visible on out_* after edge N.
//  - On accept: out_wr = in_wr & in_dest!=0; if set, pend[in_dest] is set.
//    - If wclr(in_dest) occurs in the same cycle, set wins and pend stays 1.
//  - flush while FULL & out_wr: pend[out_dest] cleared; flush while EMPTY: no effect.
//  - stall_cnt increments when in_valid & slot_free & hazard & !flush; saturates at 16'hFFFF.
//  - pend[0] is never set; writes to r0 never stall or forward.
// TESTING
//  1 Reset: drive rst=0 mid-FULL -> out_valid=0 and stall_cnt=0 immediately;
//    after release, src r3=16'h1234 issues with out_a=16'h1234 one cycle later.
//  2 RAW stall: issue wr r2, then read r2 -> in_ready=0 and stall_cnt increments;
//    on wb_en r2=16'hBEEF the instruction is accepted that same cycle with out_a=16'hBEEF.
//  3 WAW: r5 pending, new wr r5 -> stall until wb r5; on accept pend[5] remains 1.
//  4 Backpressure: out_ready=0 for 3 cycles -> out_* held stable, in_ready=0,
//    stall_cnt unchanged; out_ready=1 with a new in_valid reloads back-to-back.
//  5 Flush: FULL with wr r4, flush=1 -> out_valid=0 next cycle; a later read of r4 issues without stall.
//  6 r0: src1=0, wr dest=0 -> out_a=0, out_wr=0, no stall; wb_en r0=16'hFFFF is never forwarded.

Source files
------------

// File: rtl/operand_issue_stage_if.sv
// Issue-stage bus: decoded instruction in, register file read ports,
// writeback snoop, flush, and the ID/EX output register.
// master = surrounding pipeline, slave = operand_issue_stage.
interface operand_issue_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_src1;
    logic [ADDR_W-1:0] in_src2;
    logic              in_use1;
    logic              in_use2;
    logic [ADDR_W-1:0] in_dest;
    logic              in_wr;

    logic [ADDR_W-1:0] rf_rd_add1;
    logic [DATA_W-1:0] rf_rd_data1;
    logic [ADDR_W-1:0] rf_rd_add2;
    logic [DATA_W-1:0] rf_rd_data2;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;

    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [ADDR_W-1:0] out_dest;
    logic              out_wr;
    logic [15:0]       stall_cnt;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_use1, in_use2, in_dest, in_wr,
        output rf_rd_data1, rf_rd_data2,
        output wb_en, wb_dest, wb_data,
        output flush, out_ready,
        input  in_ready, rf_rd_add1, rf_rd_add2,
        input  out_valid, out_op, out_a, out_b, out_dest, out_wr, stall_cnt
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_use1, in_use2, in_dest, in_wr,
        input  rf_rd_data1, rf_rd_data2,
        input  wb_en, wb_dest, wb_data,
        input  flush, out_ready,
        output in_ready, rf_rd_add1, rf_rd_add2,
        output out_valid, out_op, out_a, out_b, out_dest, out_wr, stall_cnt
    );
endinterface

// File: rtl/operand_issue_stage.sv
// Operand issue stage: reads the register file, stalls on RAW/WAW hazards
// through a per-register pending scoreboard, bypasses same-cycle writeback,
// and registers operands into the ID/EX output register.
//
// state   | meaning
// S_EMPTY | output register holds nothing, out_valid=0
// S_FULL  | output register holds an instruction, out_valid=1
module operand_issue_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_issue_stage_if.slave   bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t            state;
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic [NREG-1:0]   wclr;
    logic [NREG-1:0]   busy;
    logic              hazard;
    logic              slot_free;
    logic              accept;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign bus.rf_rd_add1 = bus.in_src1;
    assign bus.rf_rd_add2 = bus.in_src2;

    // Per-register writeback clear and busy view; r0 is never busy.
    always_comb begin
        wclr = '0;
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            wclr[r] = bus.wb_en && (bus.wb_dest == ADDR_W'(r));
            busy[r] = pend[r] && !wclr[r];
        end
    end

    assign hazard = (bus.in_use1 && busy[bus.in_src1])
                  | (bus.in_use2 && busy[bus.in_src2])
                  | (bus.in_wr   && busy[bus.in_dest]);

    assign slot_free    = (state == S_EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && !hazard && slot_free && !bus.flush;
    assign bus.in_ready = accept;
    assign bus.out_valid = (state == S_FULL);

    // Operand select: zero for r0/unused, writeback bypass, else file data.
    always_comb begin
        opnd_a = bus.rf_rd_data1;
        opnd_b = bus.rf_rd_data2;
        if (!bus.in_use1 || bus.in_src1 == '0) begin
            opnd_a = '0;
        end else if (wclr[bus.in_src1]) begin
            opnd_a = bus.wb_data;
        end
        if (!bus.in_use2 || bus.in_src2 == '0) begin
            opnd_b = '0;
        end else if (wclr[bus.in_src2]) begin
            opnd_b = bus.wb_data;
        end
    end

    // Scoreboard next state: writeback and flush clear, accept sets (set wins).
    always_comb begin
        pend_nxt = pend & ~wclr;
        if (bus.flush && state == S_FULL && bus.out_wr) begin
            pend_nxt[bus.out_dest] = 1'b0;
        end
        if (accept && bus.in_wr && bus.in_dest != '0) begin
            pend_nxt[bus.in_dest] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Output register FSM; flush empties it and blocks acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_EMPTY;
            bus.out_op   <= '0;
            bus.out_a    <= '0;
            bus.out_b    <= '0;
            bus.out_dest <= '0;
            bus.out_wr   <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (bus.flush) begin
                        state <= S_EMPTY;
                    end else if (bus.out_ready && !accept) begin
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
            if (accept) begin
                bus.out_op   <= bus.in_op;
                bus.out_a    <= opnd_a;
                bus.out_b    <= opnd_b;
                bus.out_dest <= bus.in_dest;
                bus.out_wr   <= bus.in_wr && (bus.in_dest != '0);
            end
        end
    end

    // Saturating count of cycles lost to a hazard while the slot was free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.stall_cnt <= '0;
        end else if (bus.in_valid && slot_free && hazard && !bus.flush
                     && bus.stall_cnt != 16'hFFFF) begin
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
        end
    end
endmodule
